// File: rtl/xm_stage_64.sv
// xm_stage_64: execute-to-memory pipeline register with overflow traps, branch redirect and exception counter
module xm_stage_64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_result,
    input  logic        in_isNotEqual,
    input  logic        in_isLessThan,
    input  logic        in_overflow,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic        in_wren,
    input  logic [31:0] in_target,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_wren,
    output logic        redirect,
    output logic [31:0] redirect_target,
    output logic [7:0]  exc_count
);
    logic        valid_q, valid_d, wren_q, wren_d, redirect_q, redirect_d;
    logic [63:0] result_q, result_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] target_q, target_d;
    logic [7:0]  exc_q, exc_d;
    logic        cap, exc, is_br, taken;
    always_comb begin
        cap        = !flush && !stall && in_valid;
        exc        = (in_kind == 3'd1 || in_kind == 3'd2 || in_kind == 3'd3) && in_overflow;
        is_br      = in_kind == 3'd4 || in_kind == 3'd5;
        taken      = in_kind == 3'd4 ? in_isNotEqual : in_kind == 3'd5 ? in_isLessThan : 1'b0;
        valid_d    = flush ? 1'b0 : stall ? valid_q : in_valid;
        result_d   = cap ? (exc ? {61'd0, in_kind} : in_result) : result_q;
        rd_d       = cap ? (exc ? 5'd30 : in_rd) : rd_q;
        wren_d     = cap ? (exc | (in_wren & ~is_br)) : (flush || !stall) ? 1'b0 : wren_q;
        redirect_d = cap & taken;
        target_d   = cap ? in_target : target_q;
        // traps saturate rather than wrap so software can see "many" instead of a small residue
        exc_d      = (cap && exc && exc_q != 8'hFF) ? exc_q + 8'd1 : exc_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            result_q   <= 64'd0;
            rd_q       <= 5'd0;
            wren_q     <= 1'b0;
            redirect_q <= 1'b0;
            target_q   <= 32'd0;
            exc_q      <= 8'd0;
        end else begin
            valid_q    <= valid_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
            wren_q     <= wren_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            exc_q      <= exc_d;
        end
    end
    assign out_valid       = valid_q;
    assign out_result      = result_q;
    assign out_rd          = rd_q;
    assign out_wren        = wren_q;
    assign redirect        = redirect_q;
    assign redirect_target = target_q;
    assign exc_count       = exc_q;
endmodule

// File: tb/tb_xm_stage_64.sv
// tb_xm_stage_64: scoreboard bench for xm_stage_64 against an independent behavioural model
module tb_xm_stage_64;
    logic        clock = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_isNotEqual = 1'b0, in_isLessThan = 1'b0, in_overflow = 1'b0;
    logic [63:0] in_result = 64'd0;
    logic [2:0]  in_kind = 3'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_wren = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] in_target = 32'd0;
    logic        out_valid, out_wren, redirect;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic [31:0] redirect_target;
    logic [7:0]  exc_count;

    xm_stage_64 dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_result(in_result),
        .in_isNotEqual(in_isNotEqual), .in_isLessThan(in_isLessThan), .in_overflow(in_overflow),
        .in_kind(in_kind), .in_rd(in_rd), .in_wren(in_wren), .in_target(in_target),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_result(out_result),
        .out_rd(out_rd), .out_wren(out_wren), .redirect(redirect),
        .redirect_target(redirect_target), .exc_count(exc_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [63:0] r;
        logic [4:0]  rd;
        logic        w;
        logic        red;
        logic [31:0] tgt;
        logic [7:0]  ec;
        logic        data_known;
    } exp_t;

    exp_t m;
    exp_t q[$];
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    endtask

    task automatic model_reset();
        m = '{v: 1'b0, r: 64'd0, rd: 5'd0, w: 1'b0, red: 1'b0, tgt: 32'd0, ec: 8'd0, data_known: 1'b1};
    endtask

    // Behavioural next-state written as a decision tree over the instruction kind
    task automatic model_step();
        m.red = 1'b0;
        if (flush) begin
            m.v = 1'b0;
            m.w = 1'b0;
        end else if (!stall) begin
            m.v = in_valid;
            if (!in_valid) m.w = 1'b0;
            else begin
                m.tgt = in_target;
                case (in_kind)
                    3'd1, 3'd2, 3'd3: begin
                        m.data_known = 1'b1;
                        if (in_overflow) begin
                            m.r  = {61'd0, in_kind};
                            m.rd = 5'd30;
                            m.w  = 1'b1;
                            if (m.ec < 8'd255) m.ec = m.ec + 8'd1;
                        end else begin
                            m.r = in_result; m.rd = in_rd; m.w = in_wren;
                        end
                    end
                    3'd4: begin m.red = in_isNotEqual; m.w = 1'b0; m.data_known = 1'b0; end
                    3'd5: begin m.red = in_isLessThan; m.w = 1'b0; m.data_known = 1'b0; end
                    default: begin
                        m.data_known = 1'b1;
                        m.r = in_result; m.rd = in_rd; m.w = in_wren;
                    end
                endcase
            end
        end
    endtask

    task automatic compare(input exp_t e);
        chk("out_valid", out_valid, e.v);
        chk("out_wren", out_wren, e.w);
        chk("redirect", redirect, e.red);
        chk("redirect_target", redirect_target, e.tgt);
        chk("exc_count", exc_count, e.ec);
        if (e.data_known) begin
            chk("out_result", out_result, e.r);
            chk("out_rd", out_rd, e.rd);
        end
    endtask

    // Inputs are already applied; push the expectation, clock once, then pop and check
    task automatic step();
        exp_t e;
        model_step();
        q.push_back(m);
        @(posedge clock);
        #1;
        if (q.size() == 0) chk("scoreboard_empty", 1, 0);
        else begin
            e = q.pop_front();
            compare(e);
        end
    endtask

    task automatic set(input logic v, input logic [2:0] k, input logic [63:0] res, input logic ovf,
                       input logic [4:0] rd, input logic w, input logic [31:0] tgt);
        in_valid = v; in_kind = k; in_result = res; in_overflow = ovf;
        in_rd = rd; in_wren = w; in_target = tgt;
        in_isNotEqual = 1'b0; in_isLessThan = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare(m);
        reset = 1'b0;

        set(1, 3'd1, 64'h7FFF, 1, 5'd7, 0, 32'h40); step();
        chk("r029_rd", out_rd, 30); chk("r029_res", out_result, 1);
        chk("r029_wren", out_wren, 1); chk("r029_ec", exc_count, 1);

        set(1, 3'd4, 64'h55, 0, 5'd3, 1, 32'h100); in_isNotEqual = 1; step();
        chk("r030_red", redirect, 1); chk("r030_tgt", redirect_target, 32'h100); chk("r030_wren", out_wren, 0);
        set(0, 3'd0, 64'h0, 0, 5'd0, 0, 32'h0); step();
        chk("r030_idle_red", redirect, 0);

        set(1, 3'd4, 64'h1, 0, 5'd1, 1, 32'h200); step();
        set(1, 3'd5, 64'h2, 0, 5'd2, 1, 32'h300); in_isLessThan = 1; step();
        set(1, 3'd5, 64'h3, 0, 5'd3, 1, 32'h304); in_isNotEqual = 1; step();

        set(1, 3'd0, 64'hAB, 0, 5'd9, 1, 32'h10); step();
        for (int i = 0; i < 3; i++) begin
            set(1, 3'd1, 64'hDEAD + i, 1, 5'd4 + i, 1, 32'h900 + i); stall = 1; step();
            chk("r031_hold_res", out_result, 64'hAB); chk("r031_hold_ec", exc_count, 1);
        end

        set(1, 3'd4, 64'h0, 0, 5'd0, 0, 32'h500); in_isNotEqual = 1; step();
        set(1, 3'd2, 64'h0, 1, 5'd5, 0, 32'h504); stall = 1; step();
        chk("stall_kills_pulse", redirect, 0);
        set(1, 3'd0, 64'hBEEF, 0, 5'd11, 1, 32'h600); step();
        set(1, 3'd2, 64'h1, 1, 5'd5, 0, 32'h604); stall = 1; flush = 1; step();
        chk("r032_valid", out_valid, 0); chk("r032_wren", out_wren, 0); chk("r032_red", redirect, 0);
        chk("flush_keeps_res", out_result, 64'hBEEF);

        set(1, 3'd2, 64'h9, 1, 5'd6, 0, 32'h700); step();
        set(1, 3'd3, 64'h123, 0, 5'd12, 1, 32'h704); step();
        set(1, 3'd6, 64'h456, 1, 5'd13, 0, 32'h708); step();
        set(1, 3'd7, 64'h789, 1, 5'd14, 1, 32'h70C); step();
        set(1, 3'd0, 64'hABC, 1, 5'd0, 1, 32'h710); step();
        chk("r026_rd0_wren", out_wren, 1); chk("r026_rd0", out_rd, 0);

        for (int i = 0; i < 260; i++) begin
            set(1, 3'd3, 64'(i), 1, 5'(i), 0, 32'(i)); step();
        end
        chk("r033_ec", exc_count, 255); chk("r033_res", out_result, 3); chk("r033_rd", out_rd, 30);

        for (int i = 0; i < 300; i++) begin
            set($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom),
                5'($urandom), 1'($urandom), $urandom);
            in_isNotEqual = 1'($urandom); in_isLessThan = 1'($urandom);
            stall = $urandom_range(0, 3) == 0; flush = $urandom_range(0, 7) == 0;
            step();
        end

        set(1, 3'd4, 64'h0, 0, 5'd0, 0, 32'hCAFE); in_isNotEqual = 1; step();
        chk("r034_pulse", redirect, 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare(m);
        chk("r034_red0", redirect, 0);
        @(posedge clock);
        #2 reset = 1'b0;
        set(1, 3'd1, 64'h5, 1, 5'd2, 0, 32'h44); step();
        chk("r028_ec_after_reset", exc_count, 1);
        set(0, 3'd0, 64'h0, 0, 5'd0, 0, 32'h0); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/xm_stage_64.md
XM_STAGE_64 -- requirements
Module: xm_stage_64

Interface
REQ-001 SHALL have ports: clock  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have ports: in_valid  in  1  execute stage holds a live instruction this cycle.
REQ-004 SHALL have ports: in_result  in  64  64-bit ALU data_result.
REQ-005 SHALL have ports: in_isNotEqual, in_isLessThan, in_overflow  in  1 each  ALU flags.
REQ-006 SHALL have ports: in_kind  in  3  0=plain, 1=add, 2=addi, 3=sub, 4=bne, 5=blt, 6/7=plain.
REQ-007 SHALL have ports: in_rd  in  5  destination register; in_wren  in  1  instruction writes in_rd.
REQ-008 SHALL have ports: in_target  in  32  branch target PC.
REQ-009 SHALL have ports: stall  in  1  hold stage contents; flush  in  1  squash capture.
REQ-010 SHALL have ports: out_valid  out  1; out_result  out  64; out_rd  out  5; out_wren  out  1.
REQ-011 SHALL have ports: redirect  out  1  branch-taken pulse; redirect_target  out  32.
REQ-012 SHALL have ports: exc_count  out  8  saturating count of overflow exceptions.
REQ-013 SHALL be a single clock domain; reset asynchronous, active-high; no parameters.

Function
REQ-014 SHALL register all outputs; capture-to-output latency is exactly 1 cycle.
REQ-015 SHALL, per rising edge, resolve priority flush > stall > capture.
REQ-016 SHALL on flush: out_valid=0, out_wren=0, redirect=0; other data regs unchanged; exc_count unchanged.
REQ-017 SHALL on stall (no flush): hold out_valid, out_result, out_rd, out_wren, redirect_target; redirect forced 0; no count.
REQ-018 SHALL on capture: out_valid<=in_valid; if in_valid=0, out_wren<=0, redirect<=0, no count.
REQ-019 SHALL, for in_kind 1/2/3 with in_overflow=1: out_result<=kind code zero-extended (1, 2, 3), out_rd<=30, out_wren<=1, exc_count increments.
REQ-020 SHALL, for in_kind 1/2/3 with in_overflow=0, and kinds 0/6/7 regardless of overflow: out_result<=in_result, out_rd<=in_rd, out_wren<=in_wren.
REQ-021 SHALL, for in_kind 4: redirect<=in_isNotEqual; kind 5: redirect<=in_isLessThan; out_wren<=0 for both.
REQ-022 SHALL load redirect_target<=in_target on every valid capture; redirect=0 for non-branch kinds.
REQ-023 SHALL make redirect a one-cycle pulse: cleared on the next edge unless a new taken branch is captured.
REQ-024 SHALL saturate exc_count at 255 (no wrap).
REQ-025 SHALL ignore in_overflow for kinds 0, 4, 5, 6, 7.
REQ-026 SHALL hold in_wren=1 with in_rd=0 as out_wren=1, out_rd=0; register-zero suppression is downstream.

Reset
REQ-027 SHALL on reset: out_valid=0, out_result=0, out_rd=0, out_wren=0, redirect=0, redirect_target=0, exc_count=0.
REQ-028 SHALL apply reset asynchronously mid-stall or mid-redirect pulse; the first capture after deassertion behaves per REQ-015..025.

Verification
REQ-029 SHALL cover: in_valid=1, kind=1, in_overflow=1, in_rd=7, result=0x7FFF -> next cycle out_rd=30, out_result=1, out_wren=1, exc_count=1.
REQ-030 SHALL cover: kind=4, isNotEqual=1, target=0x100 -> redirect=1 one cycle, redirect_target=0x100, out_wren=0; next idle cycle redirect=0.
REQ-031 SHALL cover: captured kind=0 result 0xAB, then stall=1 for 3 cycles with changing inputs -> out_result stays 0xAB, exc_count unchanged.
REQ-032 SHALL cover: stall=1 and flush=1 together -> out_valid=0, out_wren=0, redirect=0.
REQ-033 SHALL cover: 260 consecutive overflowing subs (kind=3) -> exc_count=255, out_result=3, out_rd=30.
REQ-034 SHALL cover: reset asserted asynchronously between edges during a redirect pulse -> all outputs 0 immediately.
